// File: rtl/smol_boi_pkg.sv
// smol_boi_pkg -- shared definitions for the smol_boi SPI byte memory.
//   * default widths / synchronizer depth
//   * position of the R/W flag inside the command byte
//   * FSM state encoding
package smol_boi_pkg;

    localparam int ADDR_W_DEF      = 7;
    localparam int DATA_W_DEF      = 8;
    localparam int SYNC_STAGES_DEF = 2;

    // Command byte = {R/W, addr[6:0]}; R/W is the first bit on the wire (MSB).
    localparam int RW_BIT = 7;

    // Bit counters are 3 bits wide and wrap at the byte boundary.
    localparam int CNT_W = 3;
    localparam logic [CNT_W-1:0] CNT_LAST  = 3'd7;
    // Falling edges counted in READ_WAIT before bit 7 is driven (4th fall).
    localparam logic [CNT_W-1:0] READ_LEAD = 3'd3;

    typedef enum logic [2:0] {
        GET_ADDR,
        ADDR_TURN,
        WRITE,
        WRITE_TURN,
        READ_WAIT,
        READ,
        READ_TURN
    } state_t;

endpackage

// File: rtl/smol_boi_if.sv
// smol_boi_if -- SPI pin bundle.
//   SCLK : serial clock (asynchronous to the system clock)
//   CS   : chip select, active-low
//   MOSI : serial data into the slave, MSB first
//   MISO : serial data out of the slave, MSB first, always driven
interface smol_boi_if;
    logic SCLK;
    logic CS;
    logic MOSI;
    logic MISO;

    modport master (output SCLK, output CS, output MOSI, input MISO);
    modport slave  (input SCLK, input CS, input MOSI, output MISO);
endinterface

// File: rtl/smol_boi_input_conditioner.sv
// input_conditioner -- brings one asynchronous input into the clk domain.
//   clk, rst : system clock, asynchronous active-high reset
//   din      : raw asynchronous input
//   dout     : synchronized level (after SYNC_STAGES flops)
//   rise     : 1-clk pulse on a 0->1 transition of dout
//   fall     : 1-clk pulse on a 1->0 transition of dout
// RST_VAL is the idle level loaded on reset, so reset never produces an edge.
module input_conditioner
    import smol_boi_pkg::*;
#(
    parameter int   SYNC_STAGES = SYNC_STAGES_DEF,
    parameter logic RST_VAL     = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   prev_q, prev_d;

    always_comb begin
        // Shift towards the MSB; the MSB is the synchronized output.
        sync_d = (sync_q << 1) | SYNC_STAGES'(din);
        prev_d = sync_q[SYNC_STAGES-1];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= {SYNC_STAGES{RST_VAL}};
            prev_q <= RST_VAL;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign dout = sync_q[SYNC_STAGES-1];
    assign rise = dout & ~prev_q;
    assign fall = ~dout & prev_q;

endmodule

// File: rtl/smol_boi.sv
// smol_boi -- SPI slave in front of a 128x8 single-port byte memory.
//   CLK, RST : system clock, asynchronous active-high reset
//   spi      : SPI pins (slave modport): SCLK, CS (active-low), MOSI, MISO
// Frame: command byte {R/W, addr}, one turnaround bit, then either 8 write
// data bits plus a turnaround, or a read whose bit 7 appears on the 4th
// SCLK fall after the address and whose bits are held one SCLK period each.
// CS stays low across frames; raising it aborts the frame.
module smol_boi
    import smol_boi_pkg::*;
#(
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int DATA_W      = DATA_W_DEF,
    parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
    input  logic       CLK,
    input  logic       RST,
    smol_boi_if.slave  spi
);

    // ---------------- input conditioning ----------------
    logic sclk_s, sclk_rise, sclk_fall;
    logic cs_s,   cs_rise,   cs_fall;
    logic mosi_s, mosi_rise, mosi_fall;

    input_conditioner #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk (
        .clk(CLK), .rst(RST), .din(spi.SCLK),
        .dout(sclk_s), .rise(sclk_rise), .fall(sclk_fall)
    );

    // CS idles high (deselected) so reset does not look like a selected bus.
    input_conditioner #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_cs (
        .clk(CLK), .rst(RST), .din(spi.CS),
        .dout(cs_s), .rise(cs_rise), .fall(cs_fall)
    );

    input_conditioner #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_mosi (
        .clk(CLK), .rst(RST), .din(spi.MOSI),
        .dout(mosi_s), .rise(mosi_rise), .fall(mosi_fall)
    );

    // Only SCLK edges and the CS level drive the protocol.
    logic unused_sig;
    assign unused_sig = ^{sclk_s, cs_rise, cs_fall, mosi_rise, mosi_fall};

    // ---------------- memory ----------------
    logic [DATA_W-1:0] mem [2**ADDR_W];
    logic [DATA_W-1:0] rd_data_q;

    // ---------------- FSM state ----------------
    state_t            state_q,   state_d;
    logic [CNT_W-1:0]  cnt_q,     cnt_d;
    logic [DATA_W-1:0] sr_q,      sr_d;       // MOSI shift register
    logic [ADDR_W-1:0] addr_q,    addr_d;
    logic [DATA_W-1:0] out_q,     out_d;      // MISO shift register
    logic              miso_q,    miso_d;
    logic              wr_en_q,   wr_en_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;
    logic [DATA_W-1:0] shifted;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        sr_d      = sr_q;
        addr_d    = addr_q;
        out_d     = out_q;
        miso_d    = miso_q;
        wr_en_d   = 1'b0;
        wr_data_d = wr_data_q;
        shifted   = {sr_q[DATA_W-2:0], mosi_s};

        if (cs_s) begin
            // Deselected: restart framing, nothing is committed.
            state_d = GET_ADDR;
            cnt_d   = '0;
            sr_d    = '0;
            out_d   = '0;
            miso_d  = 1'b0;
        end else begin
            case (state_q)
                GET_ADDR: if (sclk_rise) begin
                    sr_d  = shifted;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CNT_LAST) begin
                        sr_d    = '0;
                        addr_d  = shifted[ADDR_W-1:0];
                        state_d = shifted[RW_BIT] ? READ_WAIT : ADDR_TURN;
                    end
                end
                ADDR_TURN: if (sclk_rise) state_d = WRITE;
                WRITE: if (sclk_rise) begin
                    sr_d  = shifted;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CNT_LAST) begin
                        // Commit happens one CLK later from the registered copy.
                        sr_d      = '0;
                        wr_en_d   = 1'b1;
                        wr_data_d = shifted;
                        state_d   = WRITE_TURN;
                    end
                end
                WRITE_TURN: if (sclk_rise) state_d = GET_ADDR;
                READ_WAIT: if (sclk_fall) begin
                    cnt_d = cnt_q + 1'b1;
                    // First fall is >= 4 CLK after the address, so the
                    // registered memory read is already settled.
                    if (cnt_q == '0) out_d = rd_data_q;
                    if (cnt_q == READ_LEAD) begin
                        miso_d  = out_q[DATA_W-1];
                        out_d   = {out_q[DATA_W-2:0], 1'b0};
                        cnt_d   = '0;
                        state_d = READ;
                    end
                end
                READ: if (sclk_fall) begin
                    if (cnt_q == CNT_LAST) begin
                        // Bit 0 has been held a full period.
                        miso_d  = 1'b0;
                        out_d   = '0;
                        cnt_d   = '0;
                        state_d = READ_TURN;
                    end else begin
                        miso_d = out_q[DATA_W-1];
                        out_d  = {out_q[DATA_W-2:0], 1'b0};
                        cnt_d  = cnt_q + 1'b1;
                    end
                end
                READ_TURN: if (sclk_rise) state_d = GET_ADDR;
                default: state_d = GET_ADDR;
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q   <= GET_ADDR;
            cnt_q     <= '0;
            sr_q      <= '0;
            addr_q    <= '0;
            out_q     <= '0;
            miso_q    <= 1'b0;
            wr_en_q   <= 1'b0;
            wr_data_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            sr_q      <= sr_d;
            addr_q    <= addr_d;
            out_q     <= out_d;
            miso_q    <= miso_d;
            wr_en_q   <= wr_en_d;
            wr_data_q <= wr_data_d;
        end
    end

    // Memory contents are deliberately not reset.
    always_ff @(posedge CLK) begin
        if (wr_en_q) mem[addr_q] <= wr_data_q;
        rd_data_q <= mem[addr_q];
    end

    assign spi.MISO = miso_q;

endmodule

// File: tb/tb_smol_boi.sv
// tb_smol_boi -- directed + randomized frames against a byte-array memory model.
module tb_smol_boi;

    localparam int HALF = 60;   // SCLK half period in ns (6 CLK periods)

    logic CLK = 1'b0;
    logic RST;

    smol_boi_if spi();

    smol_boi #(.ADDR_W(7), .DATA_W(8), .SYNC_STAGES(2)) dut (
        .CLK(CLK),
        .RST(RST),
        .spi(spi)
    );

    always #5 CLK = ~CLK;

    int checks   = 0;
    int failures = 0;

    // Reference model: what each address should hold, and which were written.
    logic [7:0] ref_mem [128];
    bit         written [128];
    int         wq [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One SCLK period: data set up while low, rise, then MISO is sampled
    // just before the falling edge is driven.
    task automatic spi_bit(input logic b, output logic m);
        spi.MOSI = b;
        #(HALF);
        spi.SCLK = 1'b1;
        #(HALF);
        m = spi.MISO;
        spi.SCLK = 1'b0;
    endtask

    // Write frame: cmd(8) + turn(1) + data(8) + turn(1); MISO must stay 0.
    task automatic do_write(input logic [6:0] a, input logic [7:0] d, input string tag);
        logic [17:0] bits;
        logic        m;
        logic        seen;
        bits = {1'b0, a, 1'b0, d, 1'b0};
        seen = 1'b0;
        for (int i = 17; i >= 0; i--) begin
            spi_bit(bits[i], m);
            seen = seen | m;
        end
        chk({tag, "_miso_quiet"}, {31'd0, seen}, 32'd0);
        ref_mem[a] = d;
        if (!written[a]) begin
            written[a] = 1'b1;
            wq.push_back(int'(a));
        end
    endtask

    // Read frame: cmd(8) + 12 more periods. Falls f5..f12 after the address
    // (calls 12..19) carry bits 7..0; every other sample must be 0.
    task automatic do_read(input logic [6:0] a, output logic [7:0] got, output logic noise);
        logic [7:0] cmd;
        logic       m;
        cmd   = {1'b1, a};
        got   = 8'h00;
        noise = 1'b0;
        for (int n = 1; n <= 20; n++) begin
            spi_bit((n <= 8) ? cmd[8-n] : 1'b0, m);
            if (n >= 12 && n <= 19) got[19-n] = m;
            else                    noise = noise | m;
        end
    endtask

    // Start a read and stop after ncalls SCLK periods (for abort tests).
    task automatic read_partial(input logic [6:0] a, input int ncalls);
        logic [7:0] cmd;
        logic       m;
        cmd = {1'b1, a};
        for (int n = 1; n <= ncalls; n++) spi_bit((n <= 8) ? cmd[8-n] : 1'b0, m);
    endtask

    task automatic read_check(input logic [6:0] a, input string tag);
        logic [7:0] got;
        logic       noise;
        do_read(a, got, noise);
        chk({tag, "_data"}, {24'd0, got}, {24'd0, ref_mem[a]});
        chk({tag, "_idle0"}, {31'd0, noise}, 32'd0);
    endtask

    initial begin
        logic [12:0] pw;
        logic        m;
        logic [6:0]  ra;
        logic [7:0]  rd;

        spi.SCLK = 1'b0;
        spi.CS   = 1'b0;
        spi.MOSI = 1'b0;
        RST      = 1'b1;
        #100;
        chk("reset_miso", {31'd0, spi.MISO}, 32'd0);
        RST = 1'b0;
        #100;

        // Basic write / read of 0x55.
        do_write(7'h55, 8'h33, "w55");
        read_check(7'h55, "r55");

        // Address extremes, no aliasing.
        do_write(7'h7F, 8'hA5, "w7f");
        do_write(7'h00, 8'h5A, "w00");
        read_check(7'h7F, "r7f");
        read_check(7'h00, "r00");

        // Back-to-back write then read of a fresh address.
        do_write(7'h2A, 8'hC3, "w2a");
        read_check(7'h2A, "r2a");

        // Write to 0x00 aborted after 4 data bits: memory must keep 0x5A.
        pw = {1'b0, 7'h00, 1'b0, 4'hF};
        for (int i = 12; i >= 0; i--) spi_bit(pw[i], m);
        spi.CS = 1'b1;
        #100;
        chk("cs_abort_miso", {31'd0, spi.MISO}, 32'd0);
        spi.CS = 1'b0;
        #100;
        read_check(7'h00, "r00_after_abort");

        // CS raised in the middle of a read of 0xA5: MISO shows bit 7 then drops.
        read_partial(7'h7F, 11);
        #(HALF);
        chk("mid_read_bit7", {31'd0, spi.MISO}, 32'd1);
        spi.CS = 1'b1;
        #40;
        chk("cs_read_abort_miso", {31'd0, spi.MISO}, 32'd0);
        spi.CS = 1'b0;
        #100;
        read_check(7'h7F, "r7f_after_cs");

        // RST pulsed during a read of 0xFF.
        do_write(7'h11, 8'hFF, "w11");
        read_partial(7'h11, 13);
        #(HALF);
        chk("mid_read_bit5", {31'd0, spi.MISO}, 32'd1);
        RST = 1'b1;
        #1;
        chk("rst_read_miso", {31'd0, spi.MISO}, 32'd0);
        #19;
        RST = 1'b0;
        #100;
        read_check(7'h11, "r11_after_rst");
        read_check(7'h55, "r55_after_rst");

        // Randomized back-to-back traffic.
        for (int k = 0; k < 30; k++) begin
            if (wq.size() == 0 || $urandom_range(0, 1) == 0) begin
                ra = 7'($urandom_range(0, 127));
                rd = 8'($urandom_range(0, 255));
                do_write(ra, rd, "rand_w");
            end else begin
                ra = 7'(wq[$urandom_range(0, wq.size() - 1)]);
                read_check(ra, "rand_r");
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
